// File: rtl/lzc_normalize.sv
// lzc_normalize: two-stage pipelined leading-zero count and left-normalize; valid/ready in_* mantissa in, out_data/out_shift/out_zero out
module lzc_normalize #(
  parameter int DATA_WIDTH = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COUNT_WIDTH-1:0] out_shift,
  output logic                   out_zero
);
  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s1_advance;
  logic [DATA_WIDTH-1:0]  s1_data;
  logic [COUNT_WIDTH-1:0] s1_lz;
  logic [COUNT_WIDTH-1:0] lz;
  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;
  always_comb begin
    lz = COUNT_WIDTH'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++)
      if (in_data[i]) lz = COUNT_WIDTH'(DATA_WIDTH - 1 - i);
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_data   <= '0;
      s1_lz     <= '0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_lz   <= lz;
        end
      end
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= s1_data << s1_lz;
          out_shift <= s1_lz;
          out_zero  <= s1_data == '0;
        end
      end
    end
endmodule

// File: tb/tb_lzc_normalize.sv
// tb_lzc_normalize: directed and randomized self-checking bench for lzc_normalize
module tb_lzc_normalize;
  localparam int DW = 16;
  localparam int CW = 5;
  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_shift;
  logic          out_zero;
  int            tests;
  int            fails;
  logic [DW+CW:0] q[$];
  logic [DW+CW:0] held;
  logic [DW+CW:0] e;
  logic           pend;
  logic           stalled;

  lzc_normalize #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shift(out_shift), .out_zero(out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW+CW:0] model(input logic [DW-1:0] d);
    int n = 0;
    while (n < DW && !d[DW-1-n]) n++;
    return {d == '0, CW'(n), DW'(d << n)};
  endfunction

  task automatic single(input logic [DW-1:0] din, input logic [DW-1:0] xd, input logic [CW-1:0] xs, input logic xz);
    @(posedge clk); #1 in_valid = 1'b1; in_data = din; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) chk("lat1_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("one_valid", out_valid, 1);
    chk("one_data", out_data, xd);
    chk("one_shift", out_shift, xs);
    chk("one_zero", out_zero, xz);
  endtask

  initial begin
    tests = 0; fails = 0; pend = 1'b0; stalled = 1'b0; held = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_shift", out_shift, 0);
    chk("rst_zero", out_zero, 0);

    single(16'h0001, 16'h8000, 5'd15, 1'b0);
    single(16'h0000, 16'h0000, 5'd16, 1'b1);
    single(16'h8001, 16'h8001, 5'd0, 1'b0);
    single(16'h4000, 16'h8000, 5'd1, 1'b0);

    @(posedge clk); #1 in_valid = 1'b1; in_data = 16'h00F0;
    @(posedge clk); #1 in_data = 16'h0F00;
    @(posedge clk); #1 in_data = 16'h1234;
    @(negedge clk);
    chk("b2b0_valid", out_valid, 1); chk("b2b0_data", out_data, 16'hF000); chk("b2b0_shift", out_shift, 8);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b1_valid", out_valid, 1); chk("b2b1_data", out_data, 16'hF000); chk("b2b1_shift", out_shift, 4);
    @(posedge clk);
    @(negedge clk);
    chk("b2b2_valid", out_valid, 1); chk("b2b2_data", out_data, 16'h91A0); chk("b2b2_shift", out_shift, 3);
    @(posedge clk);
    @(negedge clk) chk("b2b_empty", out_valid, 0);

    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
    @(posedge clk); #1 in_data = 16'h0003;
    @(posedge clk); #1 in_data = 16'h0007;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 16'h8000);
      chk("stall_shift", out_shift, 15);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_ready", in_ready, 1);
    chk("unstall_data", out_data, 16'h8000);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("drain1_valid", out_valid, 1); chk("drain1_data", out_data, 16'hC000); chk("drain1_shift", out_shift, 14);
    @(posedge clk);
    @(negedge clk);
    chk("drain2_valid", out_valid, 1); chk("drain2_data", out_data, 16'hE000); chk("drain2_shift", out_shift, 13);
    @(posedge clk);
    @(negedge clk) chk("drain_empty", out_valid, 0);

    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0010;
    @(posedge clk); #1 in_data = 16'h0020;
    @(posedge clk); #1 rst = 1'b1; in_data = 16'h0040;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_data", out_data, 0);
    chk("mrst_shift", out_shift, 0);
    chk("mrst_zero", out_zero, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) chk("mrst_stale", out_valid, 0);
    end

    for (int c = 0; c < 10004; c++) begin
      @(posedge clk); #1;
      if (c >= 10000) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end else begin
        if (!pend) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data = DW'($urandom) >> $urandom_range(0, DW);
        end
        out_ready = $urandom_range(0, 3) != 0;
      end
      @(negedge clk);
      if (stalled) begin
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_fields", {out_zero, out_shift, out_data}, held);
      end
      if (out_valid && out_ready) begin
        chk("rnd_qsize", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_out", {out_zero, out_shift, out_data}, e);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data));
      pend = in_valid && !in_ready;
      stalled = out_valid && !out_ready;
      held = {out_zero, out_shift, out_data};
    end
    chk("rnd_left", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lzc_normalize.md
LZC_NORMALIZE -- requirements
Module: lzc_normalize

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of mantissa in/out (legal range 4..64).
REQ-002 SHALL have parameter COUNT_WIDTH, default 5, width of the shift-count output; it SHALL satisfy 2^COUNT_WIDTH > DATA_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, in_data is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, DATA_WIDTH bits, unsigned mantissa to normalize.
REQ-008 SHALL have port out_valid, output, 1 bit, out_* fields are valid.
REQ-009 SHALL have port out_ready, input, 1 bit, downstream consumes the output this cycle.
REQ-010 SHALL have port out_data, output, DATA_WIDTH bits, in_data shifted left by out_shift.
REQ-011 SHALL have port out_shift, output, COUNT_WIDTH bits, leading-zero count of in_data; this is the shift amount for the downstream shifter.
REQ-012 SHALL have port out_zero, output, 1 bit, in_data was all zeros.

Function
REQ-013 SHALL be a two-stage pipeline: S1 registers in_data and its leading-zero count, and S2 registers the shifted data, count and zero flag.
REQ-014 SHALL have a latency of exactly 2 clk cycles from an accepted input (in_valid && in_ready) to out_valid when out_ready is held high.
REQ-015 SHALL sustain a throughput of one transfer per cycle while out_ready=1.
REQ-016 SHALL transfer a beat on an edge only when both valid and ready are high on that interface.
REQ-017 SHALL drive in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready; in_ready SHALL have no combinational dependence on in_valid.
REQ-018 SHALL, when S2 holds data and out_ready=0, hold out_valid, out_data, out_shift and out_zero stable, and S1 SHALL also hold if it is full.
REQ-019 SHALL, when S1 is full and S2 drains in the same cycle, move S1 to S2 and accept a new input into S1 in that same cycle, with no bubble.
REQ-020 SHALL compute out_shift as the number of consecutive zero bits starting at in_data[DATA_WIDTH-1], in the range 0..DATA_WIDTH-1, for nonzero input.
REQ-021 SHALL, for nonzero input, produce out_data = in_data << out_shift truncated to DATA_WIDTH bits, so that out_data[DATA_WIDTH-1] = 1.
REQ-022 SHALL, for in_data = 0, drive out_shift = DATA_WIDTH, out_data = 0 and out_zero = 1; otherwise out_zero = 0.
REQ-023 SHALL produce out_shift = 0 and out_data = in_data when in_data[DATA_WIDTH-1] = 1.
REQ-024 SHALL drop an input presented while in_ready=0; no transfer occurs and the upstream block must hold the input.
REQ-025 SHALL preserve the order of beats and SHALL NOT duplicate or drop accepted beats.

Reset
REQ-026 SHALL, on the clk edge with rst=1, clear both stage-valid flags, so out_valid=0 and the next-cycle in_ready=1.
REQ-027 SHALL reset out_data, out_shift and out_zero to 0.
REQ-028 SHALL discard any in-flight beats when rst is asserted mid-operation, and SHALL NOT emit any of them after rst deasserts.
REQ-029 SHALL ignore in_valid on any cycle with rst=1.

Verification
REQ-030 SHALL cover: DATA_WIDTH=16, in_data=0x0001 accepted, out_ready=1 -> 2 cycles later out_data=0x8000, out_shift=15, out_zero=0.
REQ-031 SHALL cover: in_data=0x0000 -> out_data=0x0000, out_shift=16, out_zero=1; also in_data=0x8001 -> out_data=0x8001, out_shift=0.
REQ-032 SHALL cover: back-to-back inputs 0x00F0, 0x0F00, 0x1234 with out_ready=1 -> outputs 0xF000/8, 0xF000/4, 0x91A0/3 on consecutive cycles.
REQ-033 SHALL cover: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats buffered, in_ready=0 after the second accept, outputs stable; on out_ready=1 the beats drain in order, none lost.
REQ-034 SHALL cover: rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 and outputs=0 the next cycle, and no stale beat emitted.
REQ-035 SHALL cover: random in_valid/out_ready for 10k cycles against a reference model -> data match, ordering preserved, and no change in outputs while stalled.
